keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD style) by strobing one column low at a time and reading the row lines back.
- This is the input-direction counterpart of the display digit-select path: time-multiplexed column drive out, row sense in.
- Debounces the rows and emits a 4-bit hex key code with a one-cycle valid strobe.
- Sits between the keypad pins and the lab's datapath/display logic.

Parameters:
- SCAN_DIV, 100000: clk cycles per column dwell; 1 ms at 100 MHz; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release; must be >= 1.
- REPEAT_DELAY, 500: used only with KEY_REPEAT_EN; samples held before the first repeat.
- REPEAT_RATE, 100: used only with KEY_REPEAT_EN; samples between subsequent repeats.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- row_n  input  4  keypad row lines; active-low, externally pulled up; asynchronous to clk.
- col_n  output  4  column strobes; active-low, exactly one bit low at all times.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key remains pressed, including the release debounce.

Behaviour:
- Synchroniser: row_n passes through two flops before use; both flops reset to 4'b1111.
- Divider: counts 0..SCAN_DIV-1 and wraps to 0. The cycle where divider = SCAN_DIV-1 is the "sample tick".
  - Rows are read only on a sample tick, so each column has a full dwell to settle.
- Column index: 2 bits. col_n = ~(4'b0001 << index), registered. Index advances (3 wraps to 0) only on a sample tick in SCAN state.
- Key map (row r, column c → code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- Multiple rows low in one sample: lowest-numbered row wins; others are ignored.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
  - SCAN: on a sample tick with any row low, latch candidate row/column, set count = 1, go to DEBOUNCE, and do not advance the column. With no row low, advance the column.
  - DEBOUNCE: column frozen. On each sample tick:
    - candidate row still low: count++.
    - otherwise: return to SCAN and advance the column.
    - when count reaches DEBOUNCE_SCANS: load key_code, pulse key_valid the next cycle, set key_held = 1, go to HELD.
    - DEBOUNCE_SCANS = 1 accepts on the first detection sample.
  - HELD: column frozen. On a sample tick with the candidate row high, set count = 1 and go to RELEASE.
  - RELEASE: candidate row high on a sample tick: count++. At DEBOUNCE_SCANS: key_held = 0, go to SCAN, advance the column. Candidate row low again: back to HELD with no new key_valid (bounce on release).
- Latency: press stable before tick k → key_valid at cycle (tick k+DEBOUNCE_SCANS-1) + 1, plus 2 cycles of synchroniser delay on the input edge.
- Second key pressed while HELD: ignored. Only the locked row/column is observed.
- Reset, including mid-debounce or mid-hold: state = SCAN, index = 0, col_n = 4'b1110, divider = 0, count = 0, key_code = 0, key_valid = 0, key_held = 0. The first scan after reset starts at column 0.
- key_code holds its value until the next accepted key.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: in HELD, count sample ticks.
  - After REPEAT_DELAY ticks, pulse key_valid with the same key_code.
  - Then pulse again every REPEAT_RATE ticks while held.
  - Leaving HELD (entering RELEASE) clears the repeat counter. Returning from RELEASE to HELD restarts REPEAT_DELAY.
- Undefined: exactly one key_valid per accepted press; no repeat counter is synthesised.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset check: assert reset for 2 cycles → col_n=4'b1110, key_valid=0, key_held=0, key_code=0; then col_n steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- Clean press: pull row_n[1] low whenever col_n[2]=0, held for 20 samples → single key_valid, key_code=4'h6, key_held=1, col_n stays 4'b1011.
- Bouncy press: row low on 2 samples, high on 1, then low steadily → the glitch does not produce key_valid; the column resumes scanning; the stable press then yields key_code 6.
- Release bounce: after acceptance, row high 2 samples, low 1, high 3 → no second key_valid; key_held falls after the third consecutive high sample; scanning resumes.
- Priority: rows 0 and 3 both low on column 3 → key_code=4'hA.
- Reset while HELD: key_held=1, assert reset → next cycle key_held=0, col_n=4'b1110, state SCAN, no key_valid.
- With KEY_REPEAT_EN (REPEAT_DELAY=5, REPEAT_RATE=2): hold key 9 → initial key_valid, then pulses at 5, 7, 9... samples into HELD, all with key_code=4'h9.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with row synchroniser, debounce and hex key code output.
// Optional macro KEY_REPEAT_EN adds auto-repeat of key_valid while a key stays held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic ONE_SCAN = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div;
    logic          tick;
    logic [1:0]    idx, idx_nx;
    logic [1:0]    cand_row, cand_row_nx, low_row;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    col_nx, code_nx;
    logic          valid_nx, held_nx, advance, any_low, cand_low;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    logic [RW-1:0] rep_cnt, rep_cnt_nx;
    logic          rep_on, rep_on_nx;
`endif

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'h0;
            4'b11_01: key_map = 4'hF;
            4'b11_10: key_map = 4'hE;
            default:  key_map = 4'hD;
        endcase
    endfunction

    assign tick     = (div == DIV_LAST);
    assign any_low  = (row_s2 != 4'hF);
    assign cand_low = ~row_s2[cand_row];

    // Lowest-numbered low row wins.
    always_comb begin
        low_row = 2'd3;
        if (!row_s2[2]) low_row = 2'd2;
        if (!row_s2[1]) low_row = 2'd1;
        if (!row_s2[0]) low_row = 2'd0;
    end

    always_comb begin
        state_nx    = state;
        cand_row_nx = cand_row;
        cnt_nx      = cnt;
        code_nx     = key_code;
        valid_nx    = 1'b0;
        held_nx     = key_held;
        advance     = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_nx  = rep_cnt;
        rep_on_nx   = rep_on;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        cand_row_nx = low_row;
                        cnt_nx      = CW'(1);
                        if (ONE_SCAN) begin
                            state_nx = HELD;
                            code_nx  = key_map(low_row, idx);
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                        end else begin
                            state_nx = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!cand_low) begin
                        state_nx = SCAN;
                        advance  = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = HELD;
                        code_nx  = key_map(cand_row, idx);
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!cand_low) begin
                        cnt_nx = CW'(1);
                        if (ONE_SCAN) begin
                            state_nx = SCAN;
                            held_nx  = 1'b0;
                            advance  = 1'b1;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = RELEASE;
                        end
`ifdef KEY_REPEAT_EN
                        rep_cnt_nx = '0;
                        rep_on_nx  = 1'b0;
                    end else if (rep_cnt == (rep_on ? RATE_LAST : DELAY_LAST)) begin
                        valid_nx   = 1'b1;
                        rep_cnt_nx = '0;
                        rep_on_nx  = 1'b1;
                    end else begin
                        rep_cnt_nx = rep_cnt + RW'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (cand_low) begin
                        state_nx = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = SCAN;
                        held_nx  = 1'b0;
                        advance  = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
        idx_nx = advance ? idx + 2'd1 : idx;
        col_nx = ~(4'b0001 << idx_nx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1    <= '1;
            row_s2    <= '1;
            div       <= '0;
            state     <= SCAN;
            idx       <= '0;
            col_n     <= 4'b1110;
            cand_row  <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_on    <= 1'b0;
`endif
        end else begin
            row_s1    <= row_n;
            row_s2    <= row_s1;
            div       <= tick ? '0 : div + DW'(1);
            state     <= state_nx;
            idx       <= idx_nx;
            col_n     <= col_nx;
            cand_row  <= cand_row_nx;
            cnt       <= cnt_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= rep_cnt_nx;
            rep_on    <= rep_on_nx;
`endif
        end
    end

endmodule
